async_fifo_write_arbiter: RTL and testbench



---
 rtl/async_fifo_pkg.sv | 15 +
 rtl/async_fifo_rr_picker.sv | 35 +++
 rtl/async_fifo_write_arbiter.sv | 111 +++++++++++
 tb/tb_async_fifo_write_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared types and helpers for the asynchronous FIFO write-side logic.
//   arb_state_t : write arbiter FSM states
//   rr_next     : wrapping increment of a requester index modulo n
package async_fifo_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_BURST
    } arb_state_t;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/async_fifo_rr_picker.sv
// Combinational round-robin search: finds the first set bit of req scanning upward
// from rr_ptr, wrapping modulo NUM_REQ.
// Ports:
//   req    in  NUM_REQ          request vector
//   rr_ptr in  $clog2(NUM_REQ)  index where the search starts
//   found  out 1                at least one request bit is set
//   idx    out $clog2(NUM_REQ)  index of the winning request (0 when none)
module async_fifo_rr_picker #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic                       found,
    output logic [$clog2(NUM_REQ)-1:0] idx
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    logic [IdxW-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest set bit wins last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            cand = IdxW'((32'(rr_ptr) + 32'(i)) % NUM_REQ);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/async_fifo_write_arbiter.sv
// Round-robin arbiter sharing the FIFO write channel among NUM_REQ requesters.
// A grant is locked for up to MAX_BURST beats or until the owner's last beat.
// Ports:
//   clk, reset_n     write-domain clock, asynchronous active-low reset
//   req_valid/last   per-requester beat valid and last-beat marker
//   req_data         per-requester beat data (unpacked array)
//   req_ready        per-requester beat accepted
//   write_fifo_push  FIFO push (equals an accepted beat)
//   write_data       FIFO write data (don't-care without push)
//   write_fifo_full  FIFO full flag, blocks all transfers
//   grant_active     a burst is locked
//   grant_id         index of the locked requester
module async_fifo_write_arbiter
    import async_fifo_pkg::*;
#(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned FIFO_DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST       = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_last,
    input  logic [FIFO_DATA_WIDTH-1:0]   req_data [NUM_REQ],
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         write_fifo_push,
    output logic [FIFO_DATA_WIDTH-1:0]   write_data,
    input  logic                         write_fifo_full,
    output logic                         grant_active,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(MAX_BURST + 1);
    localparam logic [CntW-1:0] LastBeat = CntW'(MAX_BURST - 1);

    arb_state_t      state_q, state_d;
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0] grant_id_q, grant_id_d;
    logic [CntW-1:0] beat_cnt_q, beat_cnt_d;

    logic            pick_found;
    logic [IdxW-1:0] pick_idx;
    logic            transfer;
    logic            burst_end;

    async_fifo_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req    (req_valid),
        .rr_ptr (rr_ptr_q),
        .found  (pick_found),
        .idx    (pick_idx)
    );

    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        grant_id_d      = grant_id_q;
        beat_cnt_d      = beat_cnt_q;
        req_ready       = '0;
        write_fifo_push = 1'b0;
        transfer        = 1'b0;
        burst_end       = 1'b0;
        write_data      = req_data[grant_id_q];

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    grant_id_d = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = ARB_BURST;
                end
            end
            ARB_BURST: begin
                // Ready depends only on full, so the owner sees ready even while stalled.
                req_ready[grant_id_q] = !write_fifo_full;
                transfer              = req_valid[grant_id_q] && !write_fifo_full;
                write_fifo_push       = transfer;
                burst_end             = transfer &&
                                        (req_last[grant_id_q] || (beat_cnt_q == LastBeat));
                if (transfer) begin
                    beat_cnt_d = beat_cnt_q + CntW'(1);
                end
                if (burst_end) begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = IdxW'(rr_next(32'(grant_id_q), NUM_REQ));
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ARB_IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign grant_active = (state_q == ARB_BURST);
    assign grant_id     = grant_id_q;

endmodule

// File: tb/tb_async_fifo_write_arbiter.sv
// Directed self-checking bench for async_fifo_write_arbiter (NUM_REQ=4, MAX_BURST=4).
module tb_async_fifo_write_arbiter;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [31:0] req_data [4];
    logic [3:0]  req_ready;
    logic        write_fifo_push;
    logic [31:0] write_data;
    logic        write_fifo_full;
    logic        grant_active;
    logic [1:0]  grant_id;

    int n_cmp;
    int n_err;
    int beats [4];

    async_fifo_write_arbiter #(
        .NUM_REQ         (4),
        .FIFO_DATA_WIDTH (32),
        .MAX_BURST       (4)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_last        (req_last),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .write_fifo_push (write_fifo_push),
        .write_data      (write_data),
        .write_fifo_full (write_fifo_full),
        .grant_active    (grant_active),
        .grant_id        (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next active edge; inputs are then driven there.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid       = '0;
        req_last        = '0;
        write_fifo_full = 1'b0;
        for (int i = 0; i < 4; i++) req_data[i] = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        clear_inputs();
        #3;
        check("rst_active", 32'(grant_active), 32'd0);
        check("rst_id", 32'(grant_id), 32'd0);
        check("rst_push", 32'(write_fifo_push), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rrptr", 32'(dut.rr_ptr_q), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Single requester: req 2 sends A0..A2, last on the third beat.
        req_valid   = 4'b0100;
        req_data[2] = 32'hA0;
        #1;
        check("t1_idle_active", 32'(grant_active), 32'd0);
        check("t1_idle_push", 32'(write_fifo_push), 32'd0);
        step(); #1;
        check("t1_active", 32'(grant_active), 32'd1);
        check("t1_id", 32'(grant_id), 32'd2);
        check("t1_ready", 32'(req_ready), 32'b0100);
        check("t1_push0", 32'(write_fifo_push), 32'd1);
        check("t1_data0", write_data, 32'hA0);
        step(); req_data[2] = 32'hA1; #1;
        check("t1_push1", 32'(write_fifo_push), 32'd1);
        check("t1_data1", write_data, 32'hA1);
        step(); req_data[2] = 32'hA2; req_last[2] = 1'b1; #1;
        check("t1_push2", 32'(write_fifo_push), 32'd1);
        check("t1_data2", write_data, 32'hA2);
        step(); req_valid = '0; req_last = '0; #1;
        check("t1_end_active", 32'(grant_active), 32'd0);
        check("t1_end_push", 32'(write_fifo_push), 32'd0);
        check("t1_rrptr", 32'(dut.rr_ptr_q), 32'd3);

        // Wrap-around: rr_ptr=3 with reqs 1 and 2 valid -> 1 first, then 2.
        req_valid   = 4'b0110;
        req_last    = 4'b0110;
        req_data[1] = 32'h11;
        req_data[2] = 32'h22;
        step(); #1;
        check("wr_id_a", 32'(grant_id), 32'd1);
        check("wr_push_a", 32'(write_fifo_push), 32'd1);
        check("wr_data_a", write_data, 32'h11);
        step(); req_valid = 4'b0100; #1;
        check("wr_bubble", 32'(grant_active), 32'd0);
        check("wr_rrptr_a", 32'(dut.rr_ptr_q), 32'd2);
        step(); #1;
        check("wr_id_b", 32'(grant_id), 32'd2);
        check("wr_data_b", write_data, 32'h22);
        step(); req_valid = '0; req_last = '0; #1;
        check("wr_end", 32'(grant_active), 32'd0);
        check("wr_rrptr_b", 32'(dut.rr_ptr_q), 32'd3);

        // Reset mid-burst after 2 beats of req 3, then req 0 wins first.
        req_valid   = 4'b1000;
        req_data[3] = 32'hC0;
        step(); #1;
        check("rm_id", 32'(grant_id), 32'd3);
        check("rm_push0", 32'(write_fifo_push), 32'd1);
        step(); req_data[3] = 32'hC1; #1;
        check("rm_push1", 32'(write_fifo_push), 32'd1);
        step(); req_data[3] = 32'hC2;
        reset_n = 1'b0;
        #1;
        check("rm_active", 32'(grant_active), 32'd0);
        check("rm_push", 32'(write_fifo_push), 32'd0);
        check("rm_ready", 32'(req_ready), 32'd0);
        check("rm_gid", 32'(grant_id), 32'd0);
        check("rm_rrptr", 32'(dut.rr_ptr_q), 32'd0);
        req_valid   = 4'b1001;
        req_last[0] = 1'b1;
        req_data[0] = 32'h55;
        step(); #1;
        check("rm_hold", 32'(grant_active), 32'd0);
        reset_n = 1'b1;
        step(); #1;
        check("rm_rel_active", 32'(grant_active), 32'd1);
        check("rm_rel_id", 32'(grant_id), 32'd0);
        check("rm_rel_data", write_data, 32'h55);
        step(); req_valid = '0; req_last = '0; #1;
        check("rm_rel_end", 32'(grant_active), 32'd0);

        // All four valid, no last: grants 0,1,2,3,0 with 4 beats each and a bubble.
        do_reset();
        for (int r = 0; r < 4; r++) begin
            beats[r]    = 0;
            req_data[r] = 32'h100 * 32'(r);
        end
        req_valid = 4'b1111;
        for (int b = 0; b < 5; b++) begin
            int g;
            g = b % 4;
            step(); #1;
            check("rr_active", 32'(grant_active), 32'd1);
            check("rr_id", 32'(grant_id), 32'(g));
            for (int k = 0; k < 4; k++) begin
                check("rr_push", 32'(write_fifo_push), 32'd1);
                check("rr_data", write_data, 32'h100 * 32'(g) + 32'(beats[g]));
                step();
                beats[g]++;
                req_data[g] = 32'h100 * 32'(g) + 32'(beats[g]);
                #1;
            end
            check("rr_bubble", 32'(grant_active), 32'd0);
            check("rr_bubble_push", 32'(write_fifo_push), 32'd0);
        end

        // Full backpressure for 5 cycles on the second beat of req 1's burst.
        req_valid   = 4'b0010;
        req_data[1] = 32'hB0;
        step(); #1;
        check("fb_id", 32'(grant_id), 32'd1);
        check("fb_data0", write_data, 32'hB0);
        step(); req_data[1] = 32'hB1; write_fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("fb_full_push", 32'(write_fifo_push), 32'd0);
            check("fb_full_ready", 32'(req_ready), 32'd0);
            step();
        end
        write_fifo_full = 1'b0;
        #1;
        check("fb_push1", 32'(write_fifo_push), 32'd1);
        check("fb_data1", write_data, 32'hB1);
        step(); req_data[1] = 32'hB2; #1;
        check("fb_data2", write_data, 32'hB2);
        step(); req_data[1] = 32'hB3; #1;
        check("fb_push3", 32'(write_fifo_push), 32'd1);
        check("fb_data3", write_data, 32'hB3);
        step(); req_valid = '0; #1;
        check("fb_end", 32'(grant_active), 32'd0);

        // Owner stall: req 2 drops valid for 3 cycles while req 1 is valid.
        req_valid   = 4'b0110;
        req_data[2] = 32'hD0;
        req_data[1] = 32'h77;
        step(); #1;
        check("os_id", 32'(grant_id), 32'd2);
        check("os_data0", write_data, 32'hD0);
        step(); req_data[2] = 32'hD1; req_valid = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("os_stall_push", 32'(write_fifo_push), 32'd0);
            check("os_stall_id", 32'(grant_id), 32'd2);
            check("os_stall_ready", 32'(req_ready), 32'b0100);
            step();
        end
        req_valid = 4'b0110;
        #1;
        check("os_push1", 32'(write_fifo_push), 32'd1);
        check("os_data1", write_data, 32'hD1);
        step(); req_data[2] = 32'hD2; req_last[2] = 1'b1; #1;
        check("os_data2", write_data, 32'hD2);
        step(); req_valid = 4'b0010; req_last = 4'b0010; #1;
        check("os_end", 32'(grant_active), 32'd0);
        check("os_rrptr", 32'(dut.rr_ptr_q), 32'd3);
        step(); #1;
        check("os_next_id", 32'(grant_id), 32'd1);
        check("os_next_data", write_data, 32'h77);
        step(); req_valid = '0; req_last = '0; #1;
        check("os_next_end", 32'(grant_active), 32'd0);
        check("os_rrptr2", 32'(dut.rr_ptr_q), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
